// File: rtl/sign_magnitude_table_writer.sv
// sign_magnitude_table_writer
//
// Answers sign-magnitude additions by table lookup. On leaving reset, and on
// every rebuild request, an internal generator writes the sum of every
// possible {a, b} operand pair into a table, one entry per clock. When the
// table is complete, lookups are accepted at one per cycle. Each result
// appears one cycle after it is accepted.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   rebuild    one-cycle request to regenerate the table (ignored during INIT)
//   in_valid   lookup request
//   a, b       sign-magnitude operands (MSB = sign, rest = magnitude)
//   in_ready   high only while lookups are accepted (table ready)
//   out_valid  result on sum is valid this cycle
//   sum        result: sign at bit DATA_WIDTH, magnitude in DATA_WIDTH-1:0;
//              holds its last value while out_valid is low
//   init_done  high while the table is fully written and unmodified
//
// Table contents are not cleared by reset. Only the generator rewrites them.

module sign_magnitude_table_writer #(
    parameter int unsigned DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rebuild,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH:0]   sum,
    output logic                  init_done
);

    localparam int unsigned ADDR_WIDTH = 2 * DATA_WIDTH;
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
    localparam int unsigned MAG_WIDTH  = DATA_WIDTH - 1;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_addr;

    logic [DATA_WIDTH:0]   table_mem [DEPTH];

    // Generator datapath: decode the write address into operands and form
    // their sign-magnitude sum.
    logic [DATA_WIDTH-1:0] gen_a;
    logic [DATA_WIDTH-1:0] gen_b;
    logic                  sign_a;
    logic                  sign_b;
    logic [MAG_WIDTH-1:0]  mag_a;
    logic [MAG_WIDTH-1:0]  mag_b;
    logic [DATA_WIDTH-1:0] gen_mag;
    logic                  gen_sign;
    logic [DATA_WIDTH:0]   wr_data;
    logic                  wr_en;
    logic                  accept;

    always_comb begin
        gen_a    = wr_addr[ADDR_WIDTH-1:DATA_WIDTH];
        gen_b    = wr_addr[DATA_WIDTH-1:0];
        sign_a   = gen_a[DATA_WIDTH-1];
        sign_b   = gen_b[DATA_WIDTH-1];
        mag_a    = gen_a[MAG_WIDTH-1:0];
        mag_b    = gen_b[MAG_WIDTH-1:0];
        gen_mag  = '0;
        gen_sign = 1'b0;

        if (sign_a == sign_b) begin
            // Two (DATA_WIDTH-1)-bit magnitudes always fit in DATA_WIDTH bits.
            gen_mag  = {1'b0, mag_a} + {1'b0, mag_b};
            gen_sign = sign_a;
        end else if (mag_a >= mag_b) begin
            gen_mag  = {1'b0, MAG_WIDTH'(mag_a - mag_b)};
            gen_sign = sign_a;
        end else begin
            gen_mag  = {1'b0, MAG_WIDTH'(mag_b - mag_a)};
            gen_sign = sign_b;
        end

        // Zero is always +0, including -0 + -0 and +m + -m.
        if (gen_mag == '0) begin
            gen_sign = 1'b0;
        end

        wr_data = {gen_sign, gen_mag};
    end

    assign wr_en  = (state == INIT);
    assign accept = in_valid && in_ready;

    // Table write port (generator). Not reset, so the contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_mem[wr_addr] <= wr_data;
        end
    end

    // Control FSM. in_ready and init_done are registered copies of
    // (state == READY), so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            wr_addr   <= '0;
            in_ready  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    // The last entry is written on the same edge that enters
                    // READY. The counter parks at the top rather than wrapping.
                    if (wr_addr == '1) begin
                        state     <= READY;
                        in_ready  <= 1'b1;
                        init_done <= 1'b1;
                    end else begin
                        wr_addr <= wr_addr + 1'b1;
                    end
                end
                READY: begin
                    if (rebuild) begin
                        state     <= INIT;
                        wr_addr   <= '0;
                        in_ready  <= 1'b0;
                        init_done <= 1'b0;
                    end
                end
                default: begin
                    state     <= INIT;
                    wr_addr   <= '0;
                    in_ready  <= 1'b0;
                    init_done <= 1'b0;
                end
            endcase
        end
    end

    // Registered read port. A lookup accepted with a simultaneous rebuild
    // still reads the old, complete table: the rewrite of address 0 happens
    // one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                sum <= table_mem[{a, b}];
            end
        end
    end

endmodule

// File: tb/tb_sign_magnitude_table_writer.sv
module tb_sign_magnitude_table_writer;

    localparam int DW    = 4;
    localparam int DEPTH = 1 << (2 * DW);

    logic          clk;
    logic          rst_n;
    logic          rebuild;
    logic          in_valid;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          in_ready;
    logic          out_valid;
    logic [DW:0]   sum;
    logic          init_done;

    int checks;
    int errors;

    logic [DW:0] exp_q[$];
    logic [DW:0] last_sum;

    sign_magnitude_table_writer #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rebuild   (rebuild),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .sum       (sum),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: convert to signed integers, add, convert back.
    function automatic logic [DW:0] model(input logic [DW-1:0] oa, input logic [DW-1:0] ob);
        int va;
        int vb;
        int s;
        logic [DW-2:0] ma;
        logic [DW-2:0] mb;
        ma = oa[DW-2:0];
        mb = ob[DW-2:0];
        va = oa[DW-1] ? -int'(ma) : int'(ma);
        vb = ob[DW-1] ? -int'(mb) : int'(mb);
        s  = va + vb;
        if (s < 0) return {1'b1, DW'(-s)};
        else       return {1'b0, DW'(s)};
    endfunction

    // Scoreboard monitor: every valid output pops one expected value; with
    // out_valid low, sum must hold the last delivered value.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            last_sum = '0;
        end
        if (out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid: out_valid=1 sum=%b, required no output", sum);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                if (sum !== e) begin
                    errors++;
                    $display("FAIL scoreboard_sum: got %b, required %b", sum, e);
                end
                last_sum = e;
            end
        end else begin
            checks++;
            if (out_valid !== 1'b0 || sum !== last_sum) begin
                errors++;
                $display("FAIL idle_hold: out_valid=%b sum=%b, required out_valid=0 sum=%b",
                         out_valid, sum, last_sum);
            end
        end
    end

    // Count edges until in_ready rises; returns -1 on timeout.
    task automatic count_to_ready(output int n);
        n = -1;
        for (int i = 1; i <= 1000; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL init_window_out_valid: got %b at cycle %0d, required 0", out_valid, i);
            end
            if (in_ready === 1'b1) begin
                n = i;
                in_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic drive_lookup(input logic [DW-1:0] va, input logic [DW-1:0] vb,
                                input logic [DW:0] e);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || sum !== e) begin
            errors++;
            $display("FAIL lookup_%b_%b: out_valid=%b sum=%b, required out_valid=1 sum=%b",
                     va, vb, out_valid, sum, e);
        end
    endtask

    task automatic test_reset;
        int n;
        rst_n    = 1'b0;
        rebuild  = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || init_done !== 1'b0 || out_valid !== 1'b0 || sum !== '0) begin
            errors++;
            $display("FAIL reset_outputs: in_ready=%b init_done=%b out_valid=%b sum=%b, required all 0",
                     in_ready, init_done, out_valid, sum);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_to_ready(n);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL init_length: got %0d cycles, required %0d", n, DEPTH);
        end
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_done: got %b, required 1", init_done);
        end
    endtask

    task automatic test_directed;
        drive_lookup(4'b0011, 4'b0101, 5'b01000);
        @(posedge clk); #1;
        drive_lookup(4'b1011, 4'b0101, 5'b00010);
        drive_lookup(4'b0011, 4'b1101, 5'b10010);
        @(posedge clk); #1;
        drive_lookup(4'b1111, 4'b1111, 5'b11110);
        drive_lookup(4'b0100, 4'b1100, 5'b00000);
        drive_lookup(4'b1000, 4'b1000, 5'b00000);
        drive_lookup(4'b0111, 4'b1010, 5'b00101);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        logic [2*DW-1:0] p;
        int run;
        run      = 0;
        p        = '0;
        in_valid = 1'b1;
        {a, b}   = p;
        exp_q.push_back(model(p[2*DW-1:DW], p[DW-1:0]));
        for (int i = 1; i <= DEPTH; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) run++;
            if (i < DEPTH) begin
                p      = (2*DW)'(i);
                {a, b} = p;
                exp_q.push_back(model(p[2*DW-1:DW], p[DW-1:0]));
            end else begin
                in_valid = 1'b0;
            end
        end
        checks++;
        if (run != DEPTH) begin
            errors++;
            $display("FAIL sweep_run: out_valid high %0d cycles, required %0d", run, DEPTH);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_rebuild;
        int n;
        in_valid = 1'b1;
        rebuild  = 1'b1;
        a        = 4'b0110;
        b        = 4'b0001;
        exp_q.push_back(5'b00111);
        @(posedge clk); #1;
        rebuild = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || sum !== 5'b00111 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rebuild_lookup: out_valid=%b sum=%b in_ready=%b, required 1 00111 0",
                     out_valid, sum, in_ready);
        end
        // Keep requesting during the rebuild; none may be accepted.
        in_valid = 1'b1;
        a        = 4'b0010;
        b        = 4'b0010;
        count_to_ready(n);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL rebuild_length: got %0d cycles, required %0d", n, DEPTH);
        end
        drive_lookup(4'b1110, 4'b0011, 5'b10011);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_init;
        int n;
        drive_lookup(4'b0101, 4'b0101, 5'b01010);
        rebuild = 1'b1;
        @(posedge clk); #1;
        rebuild = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || init_done !== 1'b0 || out_valid !== 1'b0 || sum !== '0) begin
            errors++;
            $display("FAIL midinit_reset: in_ready=%b init_done=%b out_valid=%b sum=%b, required all 0",
                     in_ready, init_done, out_valid, sum);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // A rebuild pulse during INIT must not restart or shorten the fill.
        @(posedge clk); #1;
        rebuild = 1'b1;
        count_to_ready(n);
        rebuild = 1'b0;
        n = n + 1;
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL restart_length: got %0d cycles, required %0d", n, DEPTH);
        end
        drive_lookup(4'b1001, 4'b0100, 5'b00011);
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_sum = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_rebuild();
        test_reset_mid_init();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
